// File: rtl/spi_ram_burst.sv
// -----------------------------------------------------------------------------
// spi_ram_burst
//
// Command-decoded single-port RAM that sits behind the SPI slave. Framed words
// arrive from the SPI receive side; read data goes back to the SPI transmit
// side through a held-output handshake.
//
// Parameters
//   ADDR_W   address width, memory depth is 2**ADDR_W words (ADDR_W <= DATA_W)
//   DATA_W   data word width / command payload width
//
// Ports
//   clk       in   single clock, everything on the rising edge
//   rst       in   synchronous active-high reset
//   rx_valid  in   din carries a command word this cycle
//   din       in   [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload
//   tx_ready  in   transmit side consumed dout this cycle
//   dout      out  read data, held stable while tx_valid=1
//   tx_valid  out  dout valid, held until accepted
//   overrun   out  sticky: a read command was dropped
//
// Opcodes: 00 load wr_addr, 01 write MEM[wr_addr], 10 load rd_addr, 11 read.
//
// Optional feature macro: SPI_RAM_AUTO_INC_EN
//   When defined, writes post-increment wr_addr and accepted reads
//   post-increment rd_addr (modulo 2**ADDR_W). When undefined, the address
//   registers change only on the load opcodes.
//
// Output state machine:
//   state | meaning
//   EMPTY | no word pending, tx_valid=0
//   FULL  | dout holds a word not yet accepted, tx_valid=1
// -----------------------------------------------------------------------------
module spi_ram_burst #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              overrun
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_LD_WR = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_LD_RD = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               overrun_q, overrun_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;

    // Memory is deliberately outside the reset domain: contents survive rst.
    logic [DATA_W-1:0]  mem [DEPTH];

    logic [1:0]         opcode;
    logic [ADDR_W-1:0]  payload_addr;
    logic [DATA_W-1:0]  payload_data;
    logic               rd_cmd;
    logic               rd_accept;
    logic               mem_we;

    assign opcode       = din[DATA_W+1:DATA_W];
    assign payload_data = din[DATA_W-1:0];
    assign payload_addr = din[ADDR_W-1:0];

    assign rd_cmd    = rx_valid && (opcode == OP_READ);
    // A pending word may be replaced only if it is being consumed this edge.
    assign rd_accept = rd_cmd && ((state_q == EMPTY) || tx_ready);

    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        overrun_d = overrun_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        mem_we    = 1'b0;

        if (rx_valid) begin
            case (opcode)
                OP_LD_WR: wr_addr_d = payload_addr;
                OP_WRITE: begin
                    mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
`endif
                end
                OP_LD_RD: rd_addr_d = payload_addr;
                default: begin
                    if (rd_accept) begin
                        dout_d = mem[rd_addr_q];
`ifdef SPI_RAM_AUTO_INC_EN
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
`endif
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            endcase
        end

        case (state_q)
            EMPTY: begin
                if (rd_accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // Accepted read with tx_ready keeps FULL: back-to-back, no bubble.
                if (!rd_accept && tx_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            dout_q    <= '0;
            overrun_q <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            overrun_q <= overrun_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_addr_q] <= payload_data;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = (state_q == FULL);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
module tb_spi_ram_burst;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              rx_valid;
    logic [DATA_W+1:0] din;
    logic              tx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              overrun;

    spi_ram_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .din      (din),
        .tx_ready (tx_ready),
        .dout     (dout),
        .tx_valid (tx_valid),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_mem [2**ADDR_W];
    bit                m_written [2**ADDR_W];
    logic [ADDR_W-1:0] m_wr, m_rd;
    logic [DATA_W-1:0] m_dout;
    bit                m_tv, m_ovr;
    logic [DATA_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_tv});
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        check("dout", {24'd0, dout}, {24'd0, m_dout});
    endtask

    // Called just after a posedge; drives one command through the next edge
    // and checks the outputs just after that edge.
    task automatic cmd(input logic [1:0] op, input logic [DATA_W-1:0] pl, input bit rdy);
        bit accepted;
        bit checkable;
        logic [DATA_W-1:0] exp;
        accepted  = 1'b0;
        checkable = 1'b0;
        rx_valid  = 1'b1;
        din       = {op, pl};
        tx_ready  = rdy;
        case (op)
            2'b00: m_wr = pl[ADDR_W-1:0];
            2'b01: begin
                m_mem[m_wr]     = pl;
                m_written[m_wr] = 1'b1;
                if (AUTO_INC) m_wr = m_wr + 1'b1;
            end
            2'b10: m_rd = pl[ADDR_W-1:0];
            default: begin
                if (!m_tv || rdy) begin
                    accepted  = 1'b1;
                    checkable = m_written[m_rd];
                    if (checkable) exp_q.push_back(m_mem[m_rd]);
                    m_tv = 1'b1;
                    if (AUTO_INC) m_rd = m_rd + 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        endcase
        if (!accepted && m_tv && rdy) m_tv = 1'b0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (accepted) begin
            if (checkable) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    m_dout = exp;
                    check("rd_data", {24'd0, dout}, {24'd0, exp});
                end
            end else begin
                m_dout = dout;
            end
        end
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        rx_valid = 1'b0;
        tx_ready = rdy;
        if (m_tv && rdy) m_tv = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_wr   = '0;
        m_rd   = '0;
        m_dout = '0;
        m_tv   = 1'b0;
        m_ovr  = 1'b0;
        exp_q.delete();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            m_mem[i]     = '0;
            m_written[i] = 1'b0;
        end
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = '0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: write then read with tx_ready high
        cmd(2'b00, 8'h10, 1'b1);
        cmd(2'b01, 8'hA5, 1'b1);
        cmd(2'b10, 8'h10, 1'b1);
        cmd(2'b11, 8'h00, 1'b1);
        check("s1_dout", {24'd0, dout}, 32'hA5);
        idle(1'b1);
        check("s1_release", {31'd0, tx_valid}, 32'd0);
        idle(1'b1);

        // 2: dropped read sets sticky overrun
        cmd(2'b10, 8'h10, 1'b0);
        cmd(2'b11, 8'h00, 1'b0);
        cmd(2'b11, 8'h00, 1'b0);
        check("s2_overrun", {31'd0, overrun}, 32'd1);
        check("s2_hold", {24'd0, dout}, 32'hA5);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        check("s2_sticky", {31'd0, overrun}, 32'd1);

        // 3: back-to-back replacement without a bubble
        cmd(2'b00, 8'h20, 1'b0);
        cmd(2'b01, 8'h3C, 1'b0);
        cmd(2'b10, 8'h10, 1'b0);
        cmd(2'b11, 8'h00, 1'b0);
        cmd(2'b10, 8'h20, 1'b0);
        cmd(2'b11, 8'h00, 1'b1);
        check("s3_dout", {24'd0, dout}, 32'h3C);
        check("s3_no_bubble", {31'd0, tx_valid}, 32'd1);
        idle(1'b1);

        // 4/5: burst across the top of the address space
        cmd(2'b00, 8'hFE, 1'b1);
        cmd(2'b01, 8'h11, 1'b1);
        cmd(2'b01, 8'h22, 1'b1);
        cmd(2'b01, 8'h33, 1'b1);
        cmd(2'b10, 8'hFE, 1'b1);
        cmd(2'b11, 8'h00, 1'b1);
        check("s4_rd0", {24'd0, dout}, AUTO_INC ? 32'h11 : 32'h33);
        cmd(2'b11, 8'h00, 1'b1);
        check("s4_rd1", {24'd0, dout}, AUTO_INC ? 32'h22 : 32'h33);
        cmd(2'b11, 8'h00, 1'b1);
        check("s4_rd2", {24'd0, dout}, 32'h33);
        idle(1'b1);

        // Write immediately followed by a read of the same location
        cmd(2'b10, 8'h41, 1'b1);
        cmd(2'b00, 8'h41, 1'b1);
        cmd(2'b01, 8'h77, 1'b1);
        cmd(2'b11, 8'h00, 1'b1);
        check("wr_then_rd", {24'd0, dout}, 32'h77);
        idle(1'b1);

        // 6: reset while holding a word, memory survives
        cmd(2'b10, 8'h10, 1'b0);
        cmd(2'b11, 8'h00, 1'b0);
        cmd(2'b11, 8'h00, 1'b0);
        tx_ready = 1'b0;
        do_reset();
        idle(1'b0);
        cmd(2'b10, 8'h20, 1'b1);
        cmd(2'b11, 8'h00, 1'b1);
        check("s6_mem_kept", {24'd0, dout}, 32'h3C);
        idle(1'b1);
        // Address registers restart at zero after reset
        do_reset();
        cmd(2'b01, 8'h99, 1'b1);
        cmd(2'b11, 8'h00, 1'b1);
        check("s6_addr_zero", {24'd0, dout}, 32'h99);
        idle(1'b1);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
